// File: rtl/rng_dice_multi_instr.sv
// Nios II multi-cycle custom instruction: rolls 1..MAX_ROLLS dice of 2..MAX_SIDES sides from a
// free-running Fibonacci LFSR with rejection sampling and returns their sum, maximum or minimum.
module rng_dice_multi_instr #(
  parameter int unsigned LFSR_WIDTH   = 16,
  parameter logic [31:0] SEED         = 32'h0000_ACE1,
  parameter int unsigned MAX_ROLLS    = 8,
  parameter int unsigned MAX_SIDES    = 32,
  parameter int unsigned DRAW_SPACING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  localparam int unsigned SPC_W = $clog2(DRAW_SPACING + 1);
  localparam logic [LFSR_WIDTH-1:0] SEED_RAW  = LFSR_WIDTH'(SEED);
  localparam logic [LFSR_WIDTH-1:0] SEED_INIT = (SEED_RAW == '0) ? LFSR_WIDTH'(1) : SEED_RAW;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRAW   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [1:0] MODE_SUM  = 2'd0;
  localparam logic [1:0] MODE_MAX  = 2'd1;
  localparam logic [1:0] MODE_MIN  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  logic [1:0]            state, state_d;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic                  feedback;
  logic [7:0]            sides_q, sides_d;
  logic [3:0]            rolls_left, rolls_d;
  logic [1:0]            mode_q, mode_d;
  logic [15:0]           acc, acc_d;
  logic [7:0]            rej, rej_d;
  logic [SPC_W-1:0]      spc, spc_d;
  logic                  err, err_d;
  logic [31:0]           result_d;
  logic                  done_d;
  logic                  bad_req;
  logic [7:0]            side_m1, smear1, smear2, mask;
  logic [7:0]            cand;
  logic                  accept;
  logic [15:0]           roll;
  logic                  unused;

  assign unused = ^{dataa[31:8], datab[31:6]};

  // Feedback taps for the supported maximal-length polynomials
  if (LFSR_WIDTH == 16) begin : g_tap16
    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  end else if (LFSR_WIDTH == 24) begin : g_tap24
    assign feedback = lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16];
  end else if (LFSR_WIDTH == 32) begin : g_tap32
    assign feedback = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
  end else begin : g_tap_bad
    assign feedback = 1'b0;
    $error("rng_dice_multi_instr: LFSR_WIDTH must be 16, 24 or 32");
  end

  assign bad_req = (dataa[7:0] < 8'd2) || (dataa[7:0] > 8'(MAX_SIDES)) ||
                   (datab[3:0] == 4'd0) || (datab[3:0] > 4'(MAX_ROLLS)) ||
                   (datab[5:4] == MODE_RSVD);

  // Smearing sides-1 rightwards yields the k-bit mask, k = ceil(log2(sides))
  always_comb begin
    side_m1 = sides_q - 8'd1;
    smear1  = side_m1 | (side_m1 >> 1);
    smear2  = smear1 | (smear1 >> 2);
    mask    = smear2 | (smear2 >> 4);
    cand    = lfsr[7:0] & mask;
    accept  = cand < sides_q;
    roll    = 16'(cand) + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    sides_d  = sides_q;
    rolls_d  = rolls_left;
    mode_d   = mode_q;
    acc_d    = acc;
    rej_d    = rej;
    spc_d    = spc;
    err_d    = err;
    result_d = result;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start && clk_en) begin
          sides_d = dataa[7:0];
          rolls_d = datab[3:0];
          mode_d  = datab[5:4];
          rej_d   = 8'd0;
          spc_d   = SPC_W'(DRAW_SPACING - 1);
          acc_d   = (datab[5:4] == MODE_MIN) ? 16'hFFFF : 16'h0000;
          if (bad_req) begin
            err_d   = 1'b1;
            acc_d   = 16'hFFFF;
            state_d = FINISH;
          end else begin
            err_d   = 1'b0;
            state_d = DRAW;
          end
        end
      end
      DRAW: begin
        // First sample after DRAW_SPACING-1 enabled cycles, then every DRAW_SPACING
        if (clk_en) begin
          if (spc <= SPC_W'(1)) begin
            spc_d = SPC_W'(DRAW_SPACING);
            if (accept) begin
              rolls_d = rolls_left - 4'd1;
              case (mode_q)
                MODE_SUM: acc_d = acc + roll;
                MODE_MAX: acc_d = (roll > acc) ? roll : acc;
                MODE_MIN: acc_d = (roll < acc) ? roll : acc;
                default:  acc_d = acc;
              endcase
              if (rolls_left == 4'd1) state_d = FINISH;
            end else if (rej != 8'hFF) begin
              rej_d = rej + 8'd1;
            end
          end else begin
            spc_d = spc - SPC_W'(1);
          end
        end
      end
      FINISH: begin
        result_d = {err, 7'd0, rej, acc};
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // LFSR free-runs regardless of clk_en; datapath follows the next-state logic
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr       <= SEED_INIT;
      sides_q    <= 8'd0;
      rolls_left <= 4'd0;
      mode_q     <= 2'd0;
      acc        <= 16'd0;
      rej        <= 8'd0;
      spc        <= '0;
      err        <= 1'b0;
      result     <= 32'd0;
      done       <= 1'b0;
    end else begin
      lfsr       <= {lfsr[LFSR_WIDTH-2:0], feedback};
      sides_q    <= sides_d;
      rolls_left <= rolls_d;
      mode_q     <= mode_d;
      acc        <= acc_d;
      rej        <= rej_d;
      spc        <= spc_d;
      err        <= err_d;
      result     <= result_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_rng_dice_multi_instr.sv
// Directed bench for rng_dice_multi_instr: an independent LFSR/draw model predicts value,
// rejection count and latency for each instruction.
module tb_rng_dice_multi_instr;

  localparam int DS   = 4;
  localparam int MAXR = 8;
  localparam int MAXS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;
  logic [15:0] m_lfsr;

  int checks   = 0;
  int failures = 0;

  rng_dice_multi_instr #(
    .LFSR_WIDTH  (16),
    .SEED        (32'h0000_ACE1),
    .MAX_ROLLS   (MAXR),
    .MAX_SIDES   (MAXS),
    .DRAW_SPACING(DS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .clk_en(clk_en),
    .start (start),
    .dataa (dataa),
    .datab (datab),
    .result(result),
    .done  (done)
  );

  always #5 clk = ~clk;

  // x^16 + x^14 + x^13 + x^11 + 1, shifted left with feedback into bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Cycle-by-cycle prediction starting from the LFSR value seen in the start cycle
  task automatic predict(input logic [15:0] l0, input logic [7:0] sides, input logic [3:0] cnt,
                         input logic [1:0] mode, input bit toggle,
                         output logic [31:0] exp_res, output int exp_lat);
    logic [15:0] l;
    logic [15:0] acc;
    logic [15:0] roll;
    logic [7:0]  mask;
    logic [7:0]  cand;
    logic [7:0]  rs;
    int k, c, need, got, rej;
    if (sides < 8'd2 || int'(sides) > MAXS || cnt == 4'd0 || int'(cnt) > MAXR || mode == 2'd3) begin
      exp_res = 32'h8000_FFFF;
      exp_lat = 2;
      return;
    end
    k = 1;
    while ((1 << k) < int'(sides)) k++;
    mask = 8'((1 << k) - 1);
    l    = l0;
    acc  = (mode == 2'd2) ? 16'hFFFF : 16'h0000;
    need = DS - 1;
    c = 0; got = 0; rej = 0;
    while (got < int'(cnt) && c < 2000) begin
      c++;
      l = lfsr_next(l);
      if (!toggle || (c % 2 == 0)) begin
        need--;
        if (need == 0) begin
          need = DS;
          cand = l[7:0] & mask;
          if (cand < sides) begin
            got++;
            roll = 16'(cand) + 16'd1;
            if (mode == 2'd0)                    acc = acc + roll;
            else if (mode == 2'd1 && roll > acc) acc = roll;
            else if (mode == 2'd2 && roll < acc) acc = roll;
          end else begin
            rej++;
          end
        end
      end
    end
    rs      = (rej > 255) ? 8'hFF : 8'(rej);
    exp_res = {1'b0, 7'd0, rs, acc};
    exp_lat = c + 2;
  endtask

  // Entered and left at a falling edge; the start is driven in the current cycle
  task automatic run(input logic [7:0] sides, input logic [3:0] cnt, input logic [1:0] mode,
                     input bit toggle, input bit poke, output logic [31:0] res);
    logic [31:0] exp_res;
    int exp_lat, lat;
    bit seen;
    dataa  = {24'hA5A5A5, sides};
    datab  = {26'h2AA_AAAA, mode, cnt};
    start  = 1'b1;
    clk_en = 1'b1;
    predict(m_lfsr, sides, cnt, mode, toggle, exp_res, exp_lat);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      start = poke && (lat == 2);
      if (start) begin
        dataa = 32'h0000_0003;
        datab = 32'h0000_0001;
      end
      clk_en = toggle ? (lat % 2 == 0) : 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("result", result, exp_res);
    end
    res = result;
    @(negedge clk);
    start  = 1'b0;
    clk_en = 1'b1;
    chk("done_one_cycle", 32'(done), 32'd0);
    if (seen) chk("result_hold", result, exp_res);
  endtask

  task automatic watch_no_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    logic [31:0] res;
    int faces[1:6];
    int n;
    reset  = 1'b1;
    clk_en = 1'b0;
    start  = 1'b0;
    dataa  = 32'd0;
    datab  = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    // Illegal requests
    run(8'd1,  4'd3, 2'd0, 1'b0, 1'b0, res);
    chk("err_sides1", res, 32'h8000_FFFF);
    run(8'd6,  4'd0, 2'd0, 1'b0, 1'b0, res);
    chk("err_count0", res, 32'h8000_FFFF);
    run(8'd6,  4'd9, 2'd0, 1'b0, 1'b0, res);
    chk("err_count9", res, 32'h8000_FFFF);
    run(8'd6,  4'd2, 2'd3, 1'b0, 1'b0, res);
    chk("err_mode3", res, 32'h8000_FFFF);
    run(8'd33, 4'd1, 2'd0, 1'b0, 1'b0, res);
    chk("err_sides33", res, 32'h8000_FFFF);
    run(8'd0,  4'd1, 2'd0, 1'b0, 1'b0, res);
    chk("err_sides0", res, 32'h8000_FFFF);

    // Legal boundaries
    run(8'd32, 4'd8, 2'd0, 1'b0, 1'b0, res);
    chk("max_args_range", 32'(res[15:0] >= 16'd8 && res[15:0] <= 16'd256), 32'd1);
    run(8'd2, 4'd1, 2'd1, 1'b0, 1'b0, res);
    chk("min_args_range", 32'(res[15:0] >= 16'd1 && res[15:0] <= 16'd2), 32'd1);

    // Sum of eight d5
    for (int i = 0; i < 20; i++) begin
      run(8'd5, 4'd8, 2'd0, 1'b0, 1'b0, res);
      chk("sum_range", 32'(res[15:0] >= 16'd8 && res[15:0] <= 16'd40), 32'd1);
      chk("sum_flags", 32'({res[31], res[30:24]}), 32'd0);
    end

    // Single d6 distribution
    for (int f = 1; f <= 6; f++) faces[f] = 0;
    for (int i = 0; i < 6000; i++) begin
      run(8'd6, 4'd1, 2'd0, 1'b0, 1'b0, res);
      if (res[15:0] >= 16'd1 && res[15:0] <= 16'd6) faces[int'(res[15:0])]++;
      else chk("d6_range", 32'(res[15:0]), 32'd1);
    end
    for (int f = 1; f <= 6; f++)
      chk("d6_face_balance", 32'(faces[f] >= 850 && faces[f] <= 1150), 32'd1);

    // Max and min of four d2
    for (int i = 0; i < 500; i++) begin
      run(8'd2, 4'd4, 2'd1, 1'b0, 1'b0, res);
      chk("max_range", 32'(res[15:0] >= 16'd1 && res[15:0] <= 16'd2), 32'd1);
    end
    for (int i = 0; i < 500; i++) begin
      run(8'd2, 4'd4, 2'd2, 1'b0, 1'b0, res);
      chk("min_range", 32'(res[15:0] >= 16'd1 && res[15:0] <= 16'd2), 32'd1);
    end

    // Stretched by clk_en gaps, with a stray start during DRAW
    for (int i = 0; i < 8; i++) run(8'd7, 4'd3, 2'(i % 3), 1'b1, 1'b1, res);

    // start while clk_en is low in IDLE must not launch
    dataa  = 32'h0000_0006;
    datab  = 32'h0000_0001;
    start  = 1'b1;
    clk_en = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    clk_en = 1'b1;
    watch_no_done(40, n);
    chk("start_no_en_ignored", 32'(n), 32'd0);

    // Reset mid-DRAW aborts silently
    dataa = 32'h0000_0006;
    datab = 32'h0000_0008;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_result_cleared", result, 32'd0);
    watch_no_done(60, n);
    chk("abort_no_done", 32'(n), 32'd0);
    run(8'd6, 4'd3, 2'd0, 1'b0, 1'b0, res);
    chk("after_abort_range", 32'(res[15:0] >= 16'd3 && res[15:0] <= 16'd18), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
